exp_input_stage: RTL and testbench

- Front end of the exponential pipeline. It accepts a float32 operand x and splits |x| into an integer part N and a fixed-point fraction f, with |x| = N + f.
- f is emitted in the pipeline's 26-bit fixed format: [25:23] integer, [22:0] fraction.
- This is the inverse direction of the back-end float re-assembly: float-to-fixed conversion with a valid/ready handshake.
- Alignment is done with a serial shifter, one bit per cycle, so latency depends on the operand.

---
 rtl/exp_pkg.sv | 19 +
 rtl/float32_unpack.sv | 35 +++
 rtl/exp_input_stage.sv | 138 +++++++++++++
 tb/tb_exp_input_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// Shared constants, state encoding and SPECIAL codes for the exponential pipeline front end.
package exp_pkg;

  localparam int FLOAT_BIAS = 127;
  localparam int FRAC_W     = 23;
  localparam int FIXED_W    = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] SP_NORMAL = 2'b00;
  localparam logic [1:0] SP_ZERO   = 2'b01;
  localparam logic [1:0] SP_OVF    = 2'b10;
  localparam logic [1:0] SP_NAN    = 2'b11;

endpackage

// File: rtl/float32_unpack.sv
// Combinational float32 field split, unbiased exponent and SPECIAL classification.
module float32_unpack
  import exp_pkg::*;
#(
  parameter int MAX_INT_EXP  = 6,
  parameter int MIN_FRAC_EXP = -24
) (
  input  logic [31:0]       x_i,
  output logic              sign_o,
  output logic [FRAC_W-1:0] mant_o,
  output logic signed [9:0] e_o,
  output logic [1:0]        special_o
);

  logic [7:0] ex;
  int         e_int;

  always_comb begin
    ex     = x_i[30:23];
    e_int  = int'(ex) - FLOAT_BIAS;
    sign_o = x_i[31];
    mant_o = x_i[FRAC_W-1:0];
    e_o    = 10'(e_int);
    if (ex == 8'hFF) begin
      special_o = SP_NAN;
    end else if (ex == 8'h00 || e_int <= MIN_FRAC_EXP) begin
      special_o = SP_ZERO;
    end else if (e_int > MAX_INT_EXP) begin
      special_o = SP_OVF;
    end else begin
      special_o = SP_NORMAL;
    end
  end

endmodule

// File: rtl/exp_input_stage.sv
// Float32 to {N, 3.23 fraction} splitter with a one-bit-per-cycle serial aligner.
// Define EXP_INPUT_ROUND_EN to round half up on the last bit lost by right shifts.
module exp_input_stage
  import exp_pkg::*;
#(
  parameter int MAX_INT_EXP  = 6,
  parameter int MIN_FRAC_EXP = -24
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [31:0]        FLOAT_x_input,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [FIXED_W-1:0] FIXED_frac_output,
  output logic [7:0]         INT_output,
  output logic               SIGN_output,
  output logic [1:0]         SPECIAL_output,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int WorkW = FRAC_W + 8;

  state_e             state_q, state_d;
  logic [WorkW-1:0]   w_q, w_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic               guard_q, guard_d;
  logic               sign_q, sign_d;
  logic [1:0]         special_q, special_d;

  logic               un_sign;
  logic [FRAC_W-1:0]  un_mant;
  logic signed [9:0]  un_e;
  logic [1:0]         un_special;

  float32_unpack #(
    .MAX_INT_EXP (MAX_INT_EXP),
    .MIN_FRAC_EXP(MIN_FRAC_EXP)
  ) u_unpack (
    .x_i      (FLOAT_x_input),
    .sign_o   (un_sign),
    .mant_o   (un_mant),
    .e_o      (un_e),
    .special_o(un_special)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      w_q       <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      guard_q   <= 1'b0;
      sign_q    <= 1'b0;
      special_q <= SP_NORMAL;
    end else begin
      w_q       <= w_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      guard_q   <= guard_d;
      sign_q    <= sign_d;
      special_q <= special_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    guard_d   = guard_q;
    sign_d    = sign_q;
    special_d = special_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d    = un_sign;
          guard_d   = 1'b0;
          special_d = un_special;
          cnt_d     = '0;
          dir_d     = 1'b0;
          case (un_special)
            SP_NORMAL: begin
              w_d     = {7'b0, 1'b1, un_mant};
              dir_d   = un_e[9];
              cnt_d   = un_e[9] ? 8'(-un_e) : 8'(un_e);
              state_d = SHIFT;
            end
            SP_OVF: begin
              w_d     = {8'h7F, {FRAC_W{1'b0}}};
              state_d = DONE;
            end
            default: begin
              w_d     = '0;
              state_d = DONE;
            end
          endcase
        end
      end
      SHIFT: begin
        if (cnt_q != 8'd0) begin
          w_d     = dir_q ? (w_q >> 1) : (w_q << 1);
          // Only right shifts lose bits; left shifts keep the guard at zero.
          guard_d = dir_q & w_q[0];
          cnt_d   = cnt_q - 8'd1;
        end else begin
`ifdef EXP_INPUT_ROUND_EN
          w_d = w_q + {{(WorkW-1){1'b0}}, guard_q};
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result fields are only exposed while DONE so no partial value leaks out.
  always_comb begin
    in_ready          = (state_q == IDLE);
    out_valid         = (state_q == DONE);
    INT_output        = out_valid ? w_q[WorkW-1:FRAC_W] : 8'h00;
    FIXED_frac_output = out_valid ? {3'b000, w_q[FRAC_W-1:0]} : '0;
    SIGN_output       = out_valid & sign_q;
    SPECIAL_output    = out_valid ? special_q : SP_NORMAL;
  end

endmodule

// File: tb/tb_exp_input_stage.sv
// Directed and random bench for exp_input_stage against a value-level reference model.
module tb_exp_input_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] FLOAT_x_input = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [25:0] FIXED_frac_output;
  logic [7:0]  INT_output;
  logic        SIGN_output;
  logic [1:0]  SPECIAL_output;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  exp_input_stage dut (
    .CLK              (CLK),
    .RST              (RST),
    .FLOAT_x_input    (FLOAT_x_input),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .FIXED_frac_output(FIXED_frac_output),
    .INT_output       (INT_output),
    .SIGN_output      (SIGN_output),
    .SPECIAL_output   (SPECIAL_output),
    .out_valid        (out_valid),
    .out_ready        (out_ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // |x| * 2^23 as an integer, truncated (or rounded half up) to 23 fraction bits.
  function automatic void model(input logic [31:0] x, output logic [1:0] sp,
                                output logic [7:0] n, output logic [22:0] f, output int lat);
    int     e;
    longint mag;
    e   = int'(x[30:23]) - 127;
    sp  = 2'b00;
    n   = 8'h00;
    f   = '0;
    lat = 0;
    if (x[30:23] == 8'hFF) begin
      sp = 2'b11;
    end else if (x[30:23] == 8'h00 || e <= -24) begin
      sp = 2'b01;
    end else if (e > 6) begin
      sp = 2'b10;
      n  = 8'h7F;
    end else begin
      mag = longint'({1'b1, x[22:0]});
      if (e >= 0) begin
        mag = mag << e;
      end else begin
`ifdef EXP_INPUT_ROUND_EN
        mag = mag + (longint'(1) << (-e - 1));
`endif
        mag = mag >> (-e);
      end
      n   = 8'(mag >> 23);
      f   = 23'(mag);
      lat = ((e < 0) ? -e : e) + 1;
    end
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_outs"}, {INT_output, 2'(SPECIAL_output), 1'(SIGN_output), 21'd0} |
          32'(FIXED_frac_output), 32'd0);
  endtask

  // Called #1 after a posedge with the DUT idle. Returns #1 after the edge that showed DONE.
  task automatic run_op(input string tag, input logic [31:0] x);
    logic [1:0]  sp;
    logic [7:0]  n;
    logic [22:0] f;
    int          lat;
    int          seen;
    model(x, sp, n, f, lat);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    FLOAT_x_input = x;
    in_valid      = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 60) begin
      @(posedge CLK);
      #1;
      seen++;
    end
    check({tag, "_latency"}, 32'(seen), 32'(lat));
    check({tag, "_int"}, 32'(INT_output), 32'(n));
    check({tag, "_frac"}, 32'(FIXED_frac_output), {9'd0, f});
    check({tag, "_sign"}, 32'(SIGN_output), 32'(x[31]));
    check({tag, "_special"}, 32'(SPECIAL_output), 32'(sp));
  endtask

  task automatic finish_op(input string tag);
    @(posedge CLK);
    #1;
    check({tag, "_back_idle"}, {31'd0, in_ready & ~out_valid}, 32'd1);
  endtask

  initial begin
    logic [31:0] rx;
    logic [7:0]  snap_int;
    logic [25:0] snap_frac;

    @(posedge CLK);
    #1;
    RST = 1'b0;
    check_idle_zero("reset");

    run_op("p2_5", 32'h40200000);
    check("p2_5_int_lit", 32'(INT_output), 32'd2);
    check("p2_5_frac_lit", 32'(FIXED_frac_output), 32'h0400000);
    finish_op("p2_5");
    run_op("p0_75", 32'h3F400000);
    check("p0_75_frac_lit", 32'(FIXED_frac_output), 32'h0600000);
    finish_op("p0_75");
    run_op("m1_0", 32'hBF800000);
    check("m1_0_sign_lit", 32'(SIGN_output), 32'd1);
    finish_op("m1_0");
    run_op("ovf200", 32'h43480000);
    check("ovf200_int_lit", 32'(INT_output), 32'h7F);
    finish_op("ovf200");
    run_op("nan", 32'h7FC00000);
    finish_op("nan");
    run_op("inf", 32'hFF800000);
    finish_op("inf");
    run_op("under25", 32'h33000000);
    check("under25_sp_lit", 32'(SPECIAL_output), 32'd1);
    finish_op("under25");
    run_op("denorm", 32'h00400001);
    finish_op("denorm");
    run_op("max_e6", 32'h42FFFFFF);
    finish_op("max_e6");
    run_op("min_e23", 32'h34000001);
    finish_op("min_e23");
    run_op("near_one", 32'h3F7FFFFF);
`ifdef EXP_INPUT_ROUND_EN
    check("near_one_lit", {INT_output, 24'(FIXED_frac_output)}, 32'h01000000);
`else
    check("near_one_lit", {INT_output, 24'(FIXED_frac_output)}, 32'h007FFFFF);
`endif
    finish_op("near_one");

    // Backpressure: hold DONE, offer another operand that must be ignored.
    out_ready = 1'b0;
    run_op("hold", 32'h40200000);
    snap_int  = INT_output;
    snap_frac = FIXED_frac_output;
    FLOAT_x_input = 32'h3F400000;
    in_valid      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_int", 32'(INT_output), 32'(snap_int));
      check("hold_frac", 32'(FIXED_frac_output), 32'(snap_frac));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    finish_op("hold");
    @(posedge CLK);
    #1;
    check("hold_no_ghost", 32'(out_valid), 32'd0);

    // Abort mid-shift with reset.
    FLOAT_x_input = 32'h358637BD;
    in_valid      = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
    end
    check("abort_busy", 32'(in_ready | out_valid), 32'd0);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    check_idle_zero("abort");
    run_op("after_abort", 32'h40200000);
    finish_op("after_abort");

    // Random operands, biased toward the normal range but covering the edges.
    for (int i = 0; i < 40; i++) begin
      rx = $urandom;
      if ($urandom_range(0, 9) < 8) rx[30:23] = 8'($urandom_range(101, 135));
      run_op("rand", rx);
      finish_op("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
